// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter and the clock dividers it checks:
// FSM encodings, default clock frequencies and the frequency-ratio helper.
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } pm_state_e;

  localparam int F_IN_DEF  = 125_000_000;
  localparam int F_OUT_DEF = 25_000_000;

  // Expected local-clock cycles per input period; 0 flags a bad configuration.
  function automatic int clk_ratio(input int f_in, input int f_out);
    return (f_out == 0) ? 0 : f_in / f_out;
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Synchronizer chain plus one delay flop, giving a clean level and a
// one-cycle rising-edge pulse; reusable by any clock monitor.
module sync_rise #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in
// cycles, flags input loss and tracks lock against the expected ratio.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int F_in        = F_IN_DEF,
  parameter int F_out       = F_OUT_DEF,
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         sig_in,
  output logic [N-1:0] period,
  output logic [N-1:0] high_time,
  output logic         valid,
  output logic         timeout,
  output logic         locked
);

  localparam int           EXPECT   = clk_ratio(F_in, F_out);
  localparam logic [N-1:0] CMAX     = '1;
  localparam logic [N-1:0] ONE      = N'(1);
  localparam logic [N-1:0] EXPECT_N = N'(EXPECT);
  localparam logic [2:0]   LOCK_N   = 3'(LOCK_COUNT);

  logic         s, rise;
  logic [N-1:0] cnt, hcnt;
  logic [2:0]   match_cnt;
  pm_state_e    state, state_nxt;
  logic         load, report, to_set;

  sync_rise #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (sig_in),
    .s      (s),
    .rise   (rise)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A rise always wins over the saturation check, so a period of exactly
  // CMAX is still reported rather than timing out.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    report    = 1'b0;
    to_set    = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_nxt = MEASURE;
        load      = 1'b1;
      end
      MEASURE: begin
        if (rise) begin
          load   = 1'b1;
          report = 1'b1;
        end else if (cnt == CMAX) begin
          state_nxt = TIMEOUT;
          to_set    = 1'b1;
        end
      end
      TIMEOUT: if (rise) begin
        state_nxt = MEASURE;
        load      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      locked    <= 1'b0;
      match_cnt <= '0;
    end else begin
      valid <= report;
      if (load) begin
        cnt  <= ONE;
        hcnt <= ONE;
      end else if (state == MEASURE) begin
        if (cnt != CMAX)         cnt  <= cnt + ONE;
        if (s && hcnt != CMAX)   hcnt <= hcnt + ONE;
      end
      if (report) begin
        period    <= cnt;
        high_time <= hcnt;
        if (cnt == EXPECT_N) begin
          if (match_cnt < LOCK_N)             match_cnt <= match_cnt + 3'd1;
          if (match_cnt >= LOCK_N - 3'd1)     locked    <= 1'b1;
        end else begin
          match_cnt <= '0;
          locked    <= 1'b0;
        end
      end else if (to_set) begin
        match_cnt <= '0;
        locked    <= 1'b0;
      end
      if (to_set)    timeout <= 1'b1;
      else if (load) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: stimulus pushes expected results,
// a negedge monitor pops and compares on every valid strobe.
module tb_period_meter;

  logic       clk_in = 1'b0;
  logic       rst, sig_in, sig3;
  logic [7:0] period, high_time, period3, high_time3;
  logic       valid, timeout, locked, valid3, timeout3, locked3;

  always #5 clk_in = ~clk_in;

  period_meter dut (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .period(period),
    .high_time(high_time), .valid(valid), .timeout(timeout), .locked(locked)
  );

  period_meter #(.SYNC_STAGES(3)) dut3 (
    .clk_in(clk_in), .rst(rst), .sig_in(sig3), .period(period3),
    .high_time(high_time3), .valid(valid3), .timeout(timeout3), .locked(locked3)
  );

  typedef struct {
    logic [7:0] p;
    logic [7:0] h;
    logic       lk;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   mc    = 0;
  bit   armed = 0;
  int   prev_p, prev_h;
  int   n;
  bit   seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Expected lock state follows the count of consecutive period-5 results.
  task automatic push(input int p, input int h);
    exp_t e;
    if (p == 5) begin
      if (mc < 4) mc++;
    end else mc = 0;
    e.p  = p[7:0];
    e.h  = h[7:0];
    e.lk = (mc == 4);
    q.push_back(e);
  endtask

  // One input period starting with a rise; that rise completes the previous period.
  task automatic cyc(input int hi, input int lo);
    if (armed) push(prev_p, prev_h);
    armed  = 1;
    prev_p = hi + lo;
    prev_h = hi;
    sig_in = 1'b1;
    repeat (hi) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (lo) @(negedge clk_in);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (valid === 1'b1) begin
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          e = q.pop_front();
          chk("period", period, e.p);
          chk("high_time", high_time, e.h);
          chk("locked", locked, e.lk);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sig_in = 1'b0; sig3 = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk_in);

    // Nominal 3-high/2-low wave: first rise arms, lock on 4th result.
    repeat (6) cyc(3, 2);
    chk("locked_after_4", locked, 1);

    // One stretched period breaks lock, four good ones restore it.
    cyc(3, 3);
    repeat (5) cyc(3, 2);
    chk("relocked", locked, 1);

    // Input loss: timeout 255 cycles after the reload edge (edge 3 after drive).
    push(prev_p, prev_h);
    armed = 0;
    sig_in = 1'b1; n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(posedge clk_in); n++;
      @(negedge clk_in);
      if (n == 3) sig_in = 1'b0;
      if (timeout === 1'b1) seen = 1;
    end
    chk("timeout_edge", n, 258);
    repeat (300 - 258) @(negedge clk_in);
    mc = 0;
    chk("timeout_level", timeout, 1);
    chk("timeout_unlock", locked, 0);
    cyc(3, 2);
    chk("timeout_cleared", timeout, 0);
    repeat (4) cyc(3, 2);
    chk("locked_before_rst", locked, 1);

    // Mid-period reset clears everything at once.
    rst = 1'b1;
    #1;
    chk("mid_rst_period", period, 0);
    chk("mid_rst_high_time", high_time, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_locked", locked, 0);
    @(negedge clk_in);
    rst = 1'b0; armed = 0; mc = 0;
    repeat (2) @(negedge clk_in);
    cyc(3, 2);
    cyc(3, 2);

    // Rise on the same cycle the counter saturates: reported, no timeout.
    cyc(3, 252);
    cyc(3, 2);
    chk("sat_no_timeout", timeout, 0);
    cyc(3, 2);
    repeat (10) @(negedge clk_in);
    chk("queue_empty", q.size(), 0);

    // Three-stage synchronizer latency on the second instance.
    sig3 = 1'b1;
    repeat (3) @(negedge clk_in);
    sig3 = 1'b0;
    repeat (3) @(negedge clk_in);
    sig3 = 1'b1; n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk_in); n++;
      @(negedge clk_in);
      if (valid3 === 1'b1) seen = 1;
    end
    chk("lat3_edges", n, 4);
    chk("period3", period3, 6);
    chk("high_time3", high_time3, 3);
    sig3 = 1'b0;
    repeat (3) @(negedge clk_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
